// File: rtl/cvm300_spi_responder.sv
// -----------------------------------------------------------------------------
// cvm300_spi_responder
//   SPI slave for the CVM300 configuration register space. A frame is 16 bits,
//   MSB first, sampled on spi_clk rise: R/W (1 = write), 7-bit address, 8-bit
//   data. Read data is shifted out on spi_clk fall. All SPI inputs are
//   oversampled by the system clock through SYNC_STAGES-deep synchronizers.
//
// Ports
//   clk          system clock, all logic on rising edge
//   reset        synchronous active-high reset
//   spi_en       frame enable from master (active high)
//   spi_clk      serial clock from master (idle low, async to clk)
//   spi_mosi     serial data from master
//   spi_miso     serial read data to master
//   spi_miso_oe  tristate enable for spi_miso, high only while read data driven
//   wr_valid     one-cycle pulse after a completed write frame
//   wr_addr      address of the last completed write
//   wr_data      data of the last completed write
//   dbg_addr     local readback address
//   dbg_data     register contents at dbg_addr (combinational)
//   abort_count  saturating count of frames ended before bit 16
// -----------------------------------------------------------------------------
module cvm300_spi_responder #(
  parameter logic [7:0] CHIP_ID     = 8'h5A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_en,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [7:0] abort_count
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  localparam logic [6:0] ID_ADDR = 7'h7F;

  state_t                 state;
  logic [SYNC_STAGES-1:0] en_sync, sclk_sync, mosi_sync;
  logic [SYNC_STAGES-1:0] fill;      // marks when the synchronizer outputs are real
  logic                   en_q, sclk_q, armed;
  logic [3:0]             bit_cnt;
  logic [7:0]             sr;
  logic [7:0]             rd_shift;
  logic [6:0]             cmd_addr;
  logic [7:0]             regs [128];

  logic en_s, sclk_s, mosi_s;
  logic en_rise, en_fall, sclk_rise, sclk_fall;
  logic [7:0] next_sr;

  assign en_s   = en_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // A rise only counts once spi_en has genuinely been seen low after reset, so
  // an enable held high across reset does not look like a fresh frame start.
  assign en_rise   = en_s & ~en_q & armed;
  assign en_fall   = ~en_s & en_q;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

  // Shift register value including the bit sampled this cycle.
  assign next_sr = {sr[6:0], mosi_s};

  assign dbg_data = (dbg_addr == ID_ADDR) ? CHIP_ID : regs[dbg_addr];

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      fill      <= '0;
    end else begin
      en_sync   <= (en_sync << 1)   | SYNC_STAGES'(spi_en);
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi_clk);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      fill      <= (fill << 1)      | SYNC_STAGES'(1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      sclk_q      <= 1'b0;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      sr          <= '0;
      rd_shift    <= '0;
      cmd_addr    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      abort_count <= '0;
      // NOTE: the register file is architecturally defined to read 00 after
      // reset, so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < 128; i++) regs[i] <= '0;
    end else begin
      en_q     <= en_s;
      sclk_q   <= sclk_s;
      wr_valid <= 1'b0;
      if (fill[SYNC_STAGES-1] && !en_s) armed <= 1'b1;

      if (en_fall) begin
        if ((state == CMD || state == WDATA || state == RDATA) && abort_count != 8'hFF)
          abort_count <= abort_count + 8'd1;
        state       <= IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (en_rise) begin
        // Also restarts a frame whose closing spi_en fall was never observed.
        state       <= CMD;
        bit_cnt     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          CMD: if (sclk_rise) begin
            sr      <= next_sr;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              cmd_addr <= next_sr[6:0];
              if (next_sr[7]) begin
                state <= WDATA;
              end else begin
                state    <= RDATA;
                rd_shift <= (next_sr[6:0] == ID_ADDR) ? CHIP_ID : regs[next_sr[6:0]];
              end
            end
          end
          WDATA: if (sclk_rise) begin
            sr      <= next_sr;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state <= DONE;
              if (cmd_addr != ID_ADDR) begin
                regs[cmd_addr] <= next_sr;
                wr_valid       <= 1'b1;
                wr_addr        <= cmd_addr;
                wr_data        <= next_sr;
              end
            end
          end
          RDATA: begin
            if (sclk_fall) begin
              spi_miso    <= rd_shift[7];
              rd_shift    <= {rd_shift[6:0], 1'b0};
              spi_miso_oe <= 1'b1;
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) state <= DONE;
            end
          end
          IDLE, DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
